image_load_ctrl: RTL and testbench

//  Sequences loading of a DEPTH-bit obstacle/boundary image from a 32-bit AXI-Stream-style word source into the lattice datapath.

---
 rtl/image_load_ctrl_pkg.sv | 11 +
 rtl/image_load_ctrl_if.sv | 26 ++
 rtl/image_load_ctrl_shift_buf.sv | 19 +
 rtl/image_load_ctrl.sv | 108 ++++++++++
 tb/tb_image_load_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/image_load_ctrl_pkg.sv
// image_load_ctrl_pkg: shared widths, default image depth and FSM state encoding.
// The ST_RESYNC state exists only when IMG_TLAST_CHECK_EN is defined.
package image_load_ctrl_pkg;
  localparam int DEPTH_DEF = 128;
  localparam int WORD_W = 32;
`ifdef IMG_TLAST_CHECK_EN
  typedef enum logic [1:0] {ST_FILL, ST_HOLD, ST_RESYNC} state_t;
`else
  typedef enum logic [1:0] {ST_FILL, ST_HOLD} state_t;
`endif
endpackage

// File: rtl/image_load_ctrl_if.sv
// image_load_ctrl_if: word stream handshake between the stream source (master) and the loader (slave).
// Signals: valid, ready, data[W-1:0], and last when IMG_TLAST_CHECK_EN is defined.
interface image_load_ctrl_if #(parameter int W = 32);
  logic valid;
  logic ready;
  logic [W-1:0] data;
`ifdef IMG_TLAST_CHECK_EN
  logic last;
`endif
  modport master(
    output valid,
    output data,
`ifdef IMG_TLAST_CHECK_EN
    output last,
`endif
    input ready
  );
  modport slave(
    input valid,
    input data,
`ifdef IMG_TLAST_CHECK_EN
    input last,
`endif
    output ready
  );
endinterface

// File: rtl/image_load_ctrl_shift_buf.sv
// image_load_ctrl_shift_buf: DEPTH-bit assembly buffer, shifts a word in at the LSB end.
// Ports: clk, rst_n (async active-low), shift (load enable), clr (sync clear), din[W-1:0], q[DEPTH-1:0].
// The oldest word leaves through the MSB end, so surplus high bits of the first word are dropped.
module image_load_ctrl_shift_buf #(
  parameter int DEPTH = 128,
  parameter int W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift,
  input  logic             clr,
  input  logic [W-1:0]     din,
  output logic [DEPTH-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (clr) q <= '0;
    else if (shift) q <= DEPTH'({q, din});
endmodule

// File: rtl/image_load_ctrl.sv
// image_load_ctrl: assembles a DEPTH-bit image from 32-bit words and commits it atomically outside the collision phase.
// Ports: clk, rst_n (async active-low), s (stream slave), clear (sync abort), in_collision_state,
//   img_data (committed image), img_update (1-cycle commit pulse), frame_cnt (committed frames),
//   busy (frame held, commit pending), err_frame (sticky framing error, only with IMG_TLAST_CHECK_EN).
// Optional feature macro: IMG_TLAST_CHECK_EN enables s.last framing checks and the RESYNC state.
module image_load_ctrl
  import image_load_ctrl_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  image_load_ctrl_if.slave   s,
  input  logic               clear,
  input  logic               in_collision_state,
  output logic [DEPTH-1:0]   img_data,
  output logic               img_update,
  output logic [15:0]        frame_cnt,
`ifdef IMG_TLAST_CHECK_EN
  output logic               err_frame,
`endif
  output logic               busy
);
  localparam int NWORDS = (DEPTH + WORD_W - 1) / WORD_W;
  localparam int CW = NWORDS > 1 ? $clog2(NWORDS) : 1;
  state_t state, state_n;
  logic [CW-1:0] count, count_n;
  logic [DEPTH-1:0] sbuf;
  logic beat, last_word, shift, bclr, commit;
`ifdef IMG_TLAST_CHECK_EN
  logic err_set;
`endif
  assign s.ready = state != ST_HOLD;
  assign busy = state == ST_HOLD;
  assign beat = s.valid & s.ready;
  assign last_word = count == CW'(NWORDS - 1);
  image_load_ctrl_shift_buf #(.DEPTH(DEPTH), .W(WORD_W)) u_buf (
    .clk(clk),
    .rst_n(rst_n),
    .shift(shift),
    .clr(bclr),
    .din(s.data),
    .q(sbuf)
  );
  // clear overrides everything, including a final beat or a pending commit in the same cycle
  always_comb begin
    state_n = state;
    count_n = count;
    shift = 1'b0;
    bclr = 1'b0;
    commit = 1'b0;
`ifdef IMG_TLAST_CHECK_EN
    err_set = 1'b0;
`endif
    if (clear) begin
      state_n = ST_FILL;
      count_n = '0;
      bclr = 1'b1;
    end else begin
      case (state)
        ST_HOLD: begin
          commit = !in_collision_state;
          state_n = in_collision_state ? ST_HOLD : ST_FILL;
        end
`ifdef IMG_TLAST_CHECK_EN
        ST_RESYNC: state_n = beat && s.last ? ST_FILL : ST_RESYNC;
`endif
        default: if (beat) begin
`ifdef IMG_TLAST_CHECK_EN
          // last early: restart framing at once; last missing: discard until the source's next last
          if (s.last != last_word) begin
            err_set = 1'b1;
            count_n = '0;
            bclr = 1'b1;
            state_n = last_word ? ST_RESYNC : ST_FILL;
          end else
`endif
          begin
            shift = 1'b1;
            count_n = last_word ? '0 : count + 1'b1;
            state_n = last_word ? ST_HOLD : ST_FILL;
          end
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_FILL;
      count <= '0;
      img_data <= '0;
      img_update <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state <= state_n;
      count <= count_n;
      img_update <= commit;
      if (commit) begin
        img_data <= sbuf;
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
`ifdef IMG_TLAST_CHECK_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_frame <= 1'b0;
    else if (err_set) err_frame <= 1'b1;
`endif
endmodule

// File: tb/tb_image_load_ctrl.sv
// tb_image_load_ctrl: randomized stimulus against a queue-based frame model, plus literal checks of key scenarios.
module tb_image_load_ctrl;
  import image_load_ctrl_pkg::*;
  localparam int DEPTH = 128;
  localparam int NW = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic coll_man = 1'b0;
  logic coll_rnd = 1'b0;
  logic rnd_en = 1'b0;
  logic coll;
  logic [DEPTH-1:0] img_data;
  logic img_update;
  logic [15:0] frame_cnt;
  logic busy;
`ifdef IMG_TLAST_CHECK_EN
  logic err_frame;
  bit m_err = 0;
  bit resync = 0;
`endif
  int checks = 0;
  int errors = 0;
  logic [31:0] words[$];
  bit held = 0;
  bit prev_upd = 0;
  bit m_upd = 0;
  logic [DEPTH-1:0] m_held = '0;
  logic [DEPTH-1:0] m_img = '0;
  logic [15:0] m_cnt = '0;

  assign coll = coll_man | coll_rnd;
  image_load_ctrl_if #(.W(WORD_W)) s_if ();
  image_load_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s(s_if),
    .clear(clear),
    .in_collision_state(coll),
    .img_data(img_data),
    .img_update(img_update),
    .frame_cnt(frame_cnt),
`ifdef IMG_TLAST_CHECK_EN
    .err_frame(err_frame),
`endif
    .busy(busy)
  );
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DEPTH-1:0] act, input logic [DEPTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // A frame is simply the concatenation of its words, first word most significant.
  task automatic accept(input logic [31:0] w);
    logic [DEPTH-1:0] img = '0;
    words.push_back(w);
    if (words.size() == NW) begin
      foreach (words[i]) img = (img << 32) | DEPTH'(words[i]);
      m_held = img;
      held = 1;
      words.delete();
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      words.delete();
      held = 0;
      m_upd = 0;
      m_img = '0;
      m_cnt = '0;
`ifdef IMG_TLAST_CHECK_EN
      m_err = 0;
      resync = 0;
`endif
    end else begin
      m_upd = 0;
      if (clear) begin
        words.delete();
        held = 0;
`ifdef IMG_TLAST_CHECK_EN
        resync = 0;
`endif
      end else if (held) begin
        if (!coll) begin
          m_img = m_held;
          m_cnt++;
          m_upd = 1;
          held = 0;
        end
      end else if (s_if.valid) begin
`ifdef IMG_TLAST_CHECK_EN
        if (resync) begin
          if (s_if.last) resync = 0;
        end else if (s_if.last && words.size() != NW - 1) begin
          m_err = 1;
          words.delete();
        end else if (!s_if.last && words.size() == NW - 1) begin
          m_err = 1;
          resync = 1;
          words.delete();
        end else accept(s_if.data);
`else
        accept(s_if.data);
`endif
      end
    end
    #2;
    chk("img_data", img_data, m_img);
    chk("img_update", img_update, m_upd);
    chk("frame_cnt", frame_cnt, m_cnt);
    chk("busy", busy, held);
    chk("s_ready", s_if.ready, !held);
    chk("update_back_to_back", prev_upd & img_update, 0);
`ifdef IMG_TLAST_CHECK_EN
    chk("err_frame", err_frame, m_err);
`endif
    prev_upd = img_update;
  end

  initial forever begin
    @(negedge clk);
    coll_rnd = rnd_en && ($urandom_range(0, 2) == 0);
  end

  task automatic send(input logic [31:0] w, input logic l);
    int n = 0;
    s_if.valid = 1'b1;
    s_if.data = w;
`ifdef IMG_TLAST_CHECK_EN
    s_if.last = l;
`else
    if (l) n = 0;
`endif
    while (!s_if.ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got ready=0 for %0d cycles expected ready", n);
    end
    @(negedge clk);
    s_if.valid = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] f[4], input int gap);
    for (int i = 0; i < 4; i++) begin
      send(f[i], i == 3);
      repeat ($urandom_range(0, gap)) @(negedge clk);
    end
  endtask

  task automatic wait_upd();
    int n = 0;
    while (!img_update && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL wait_update: got no img_update in %0d cycles expected one", n);
    end
  endtask

  task automatic rand_frame(output logic [31:0] f[4]);
    foreach (f[i]) f[i] = $urandom;
  endtask

  initial begin
    logic [31:0] f[4];
    s_if.valid = 1'b0;
    s_if.data = '0;
`ifdef IMG_TLAST_CHECK_EN
    s_if.last = 1'b0;
`endif
    #1;
    chk("reset_img", img_data, 0);
    chk("reset_cnt", frame_cnt, 0);
    chk("reset_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // 1: back-to-back frame, no collision
    f = '{32'hA1A1_0001, 32'hB2B2_0002, 32'hC3C3_0003, 32'hD4D4_0004};
    send_frame(f, 0);
    wait_upd();
    chk("t1_data", img_data, 128'hA1A1_0001_B2B2_0002_C3C3_0003_D4D4_0004);
    chk("t1_cnt", frame_cnt, 1);
    @(negedge clk);
    chk("t1_pulse_len", img_update, 0);
    // 2: frame completes during collision, held for 10 cycles
    coll_man = 1'b1;
    f = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    send_frame(f, 0);
    repeat (10) begin
      @(negedge clk);
      chk("t2_busy", busy, 1);
      chk("t2_ready", s_if.ready, 0);
      chk("t2_no_update", img_update, 0);
    end
    coll_man = 1'b0;
    wait_upd();
    chk("t2_data", img_data, 128'h1111_1111_2222_2222_3333_3333_4444_4444);
    chk("t2_cnt", frame_cnt, 2);
    // 3: gapped random frames with random collision
    rnd_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rand_frame(f);
      send_frame(f, 3);
      wait_upd();
      chk("t3_data", img_data, {f[0], f[1], f[2], f[3]});
    end
    rnd_en = 1'b0;
    chk("t3_cnt", frame_cnt, 5);
    @(negedge clk);
    // 4: clear after 2 words, then a clean frame
    send(32'hDEAD_0001, 0);
    send(32'hDEAD_0002, 0);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    f = '{32'hEEEE_0005, 32'hFFFF_0006, 32'h6666_0007, 32'h7777_0008};
    send_frame(f, 1);
    wait_upd();
    chk("t4_data", img_data, 128'hEEEE_0005_FFFF_0006_6666_0007_7777_0008);
    chk("t4_cnt", frame_cnt, 6);
    // clear while holding with collision dropping in the same cycle
    coll_man = 1'b1;
    rand_frame(f);
    send_frame(f, 0);
    clear = 1'b1;
    coll_man = 1'b0;
    @(negedge clk);
    clear = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t4_hold_clear_no_update", img_update, 0);
    end
    chk("t4_hold_clear_cnt", frame_cnt, 6);
    chk("t4_hold_clear_busy", busy, 0);
    // clear coinciding with the final beat drops that beat
    for (int i = 0; i < 3; i++) send($urandom, 0);
    s_if.valid = 1'b1;
    s_if.data = 32'hBAD0_BAD0;
`ifdef IMG_TLAST_CHECK_EN
    s_if.last = 1'b1;
`endif
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    s_if.valid = 1'b0;
    chk("t4_final_clear_busy", busy, 0);
    f = '{32'h0A0A_0A0A, 32'h0B0B_0B0B, 32'h0C0C_0C0C, 32'h0D0D_0D0D};
    send_frame(f, 0);
    wait_upd();
    chk("t4_final_clear_data", img_data, 128'h0A0A_0A0A_0B0B_0B0B_0C0C_0C0C_0D0D_0D0D);
    chk("t4_final_clear_cnt", frame_cnt, 7);
    // 5: reset mid-frame
    for (int i = 0; i < 3; i++) send($urandom, 0);
    rst_n = 1'b0;
    #1;
    chk("t5_img", img_data, 0);
    chk("t5_cnt", frame_cnt, 0);
    chk("t5_upd", img_update, 0);
    chk("t5_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    f = '{32'h5555_0001, 32'h5555_0002, 32'h5555_0003, 32'h5555_0004};
    send_frame(f, 0);
    wait_upd();
    chk("t5_data", img_data, 128'h5555_0001_5555_0002_5555_0003_5555_0004);
    chk("t5_cnt_after", frame_cnt, 1);
`ifdef IMG_TLAST_CHECK_EN
    // 6: early last, then missing last with resync
    chk("t6_err_clean", err_frame, 0);
    send(32'h6000_0001, 0);
    send(32'h6000_0002, 1);
    chk("t6_err_early", err_frame, 1);
    f = '{32'h6100_0001, 32'h6100_0002, 32'h6100_0003, 32'h6100_0004};
    send_frame(f, 0);
    wait_upd();
    chk("t6_early_data", img_data, 128'h6100_0001_6100_0002_6100_0003_6100_0004);
    chk("t6_early_cnt", frame_cnt, 2);
    for (int i = 0; i < 6; i++) send($urandom, 0);
    chk("t6_resync_busy", busy, 0);
    send($urandom, 1);
    f = '{32'h6200_0001, 32'h6200_0002, 32'h6200_0003, 32'h6200_0004};
    send_frame(f, 0);
    wait_upd();
    chk("t6_resync_data", img_data, 128'h6200_0001_6200_0002_6200_0003_6200_0004);
    chk("t6_resync_cnt", frame_cnt, 3);
`endif
    // soak: random frames, gaps, collision and occasional clears, checked by the model
    rnd_en = 1'b1;
    for (int k = 0; k < 30; k++) begin
      rand_frame(f);
      for (int i = 0; i < 4; i++) begin
        send(f[i], i == 3);
        if ($urandom_range(0, 15) == 0) begin
          clear = 1'b1;
          @(negedge clk);
          clear = 1'b0;
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    rnd_en = 1'b0;
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish by time limit expected completion");
    $fatal(1);
  end
endmodule
